// File: rtl/x_23k640_req_queue_if.sv
// Application-side request/completion bundle for the 23K640 request queue.
// The slave modport is the queue itself; the master modport is the requesting client.
interface x_23k640_req_queue_if #(
  parameter int TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_rd_n_wr;
  logic [15:0]      req_addr;
  logic [7:0]       req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             cpl_valid;
  logic             cpl_ready;
  logic             cpl_rd_n_wr;
  logic [TAG_W-1:0] cpl_tag;
  logic [7:0]       cpl_rdata;

  modport slave (
    input  req_valid, req_rd_n_wr, req_addr, req_wdata, req_tag, cpl_ready,
    output req_ready, cpl_valid, cpl_rd_n_wr, cpl_tag, cpl_rdata
  );

  modport master (
    output req_valid, req_rd_n_wr, req_addr, req_wdata, req_tag, cpl_ready,
    input  req_ready, cpl_valid, cpl_rd_n_wr, cpl_tag, cpl_rdata
  );
endinterface

// File: rtl/x_23k640_req_queue.sv
// Tagged request FIFO, in-order completion buffer and stall-aware advance strobe
// sitting in front of the 23K640 SPI SRAM controller.
module x_23k640_req_queue #(
  parameter int DEPTH     = 4,
  parameter int CPL_DEPTH = 2,
  parameter int ADV_DIV   = 4,
  parameter int TAG_W     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  x_23k640_req_queue_if.slave   app,
  output logic                  o_advance,
  output logic                  o_valid,
  input  logic                  i_accept,
  output logic                  o_rd_n_wr,
  output logic [15:0]           o_addr,
  output logic [7:0]            o_wdata,
  input  logic                  i_ready,
  input  logic [7:0]            i_rdata
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CPTR_W = $clog2(CPL_DEPTH);
  localparam int CCNT_W = CPTR_W + 1;
  localparam int ADV_W  = (ADV_DIV > 1) ? $clog2(ADV_DIV) : 1;

  typedef struct packed {
    logic             rd_n_wr;
    logic [15:0]      addr;
    logic [7:0]       wdata;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic             rd_n_wr;
    logic [TAG_W-1:0] tag;
    logic [7:0]       rdata;
  } cpl_t;

  req_t               req_mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop;
  req_t               req_in, head;

  cpl_t               cpl_mem_q [CPL_DEPTH];
  logic [CPTR_W-1:0]  cpl_wr_ptr_q, cpl_wr_ptr_d, cpl_rd_ptr_q, cpl_rd_ptr_d;
  logic [CCNT_W-1:0]  cpl_cnt_q, cpl_cnt_d;
  logic               cpl_push, cpl_pop;
  cpl_t               cpl_in, cpl_head;

  logic [ADV_W-1:0]   adv_cnt_q, adv_cnt_d;
  logic               adv_q, adv_d;
  logic               stall, adv_wrap;

  // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
  assign app.req_ready = (cnt_q != CNT_W'(DEPTH));
  assign o_valid       = (cnt_q != '0);
  assign push          = app.req_valid & app.req_ready;
  assign pop           = i_accept & o_valid;

  assign req_in = '{rd_n_wr: app.req_rd_n_wr, addr: app.req_addr,
                    wdata: app.req_wdata, tag: app.req_tag};
  assign head   = req_mem_q[rd_ptr_q];

  assign o_rd_n_wr = o_valid & head.rd_n_wr;
  assign o_addr    = o_valid ? head.addr  : '0;
  assign o_wdata   = o_valid ? head.wdata : '0;

  assign cpl_push = pop;
  assign cpl_pop  = app.cpl_valid & app.cpl_ready;
  assign cpl_in   = '{rd_n_wr: head.rd_n_wr, tag: head.tag,
                      rdata: (head.rd_n_wr & i_ready) ? i_rdata : 8'h00};
  assign cpl_head = cpl_mem_q[cpl_rd_ptr_q];

  assign app.cpl_valid   = (cpl_cnt_q != '0);
  assign app.cpl_rd_n_wr = app.cpl_valid & cpl_head.rd_n_wr;
  assign app.cpl_tag     = app.cpl_valid ? cpl_head.tag   : '0;
  assign app.cpl_rdata   = app.cpl_valid ? cpl_head.rdata : '0;

  assign stall    = (cpl_cnt_q == CCNT_W'(CPL_DEPTH));
  assign adv_wrap = (adv_cnt_q == ADV_W'(ADV_DIV - 1));
  assign o_advance = adv_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_comb begin
    cpl_wr_ptr_d = cpl_wr_ptr_q;
    cpl_rd_ptr_d = cpl_rd_ptr_q;
    cpl_cnt_d    = cpl_cnt_q;
    if (cpl_push) cpl_wr_ptr_d = cpl_wr_ptr_q + CPTR_W'(1);
    if (cpl_pop)  cpl_rd_ptr_d = cpl_rd_ptr_q + CPTR_W'(1);
    if (cpl_push && !cpl_pop)      cpl_cnt_d = cpl_cnt_q + CCNT_W'(1);
    else if (!cpl_push && cpl_pop) cpl_cnt_d = cpl_cnt_q - CCNT_W'(1);
  end

  // A full completion buffer freezes the divider, so the controller cannot start another transfer.
  always_comb begin
    adv_cnt_d = adv_cnt_q;
    adv_d     = 1'b0;
    if (!stall) begin
      adv_d     = adv_wrap;
      adv_cnt_d = adv_wrap ? '0 : adv_cnt_q + ADV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      cpl_wr_ptr_q <= '0;
      cpl_rd_ptr_q <= '0;
      cpl_cnt_q    <= '0;
      adv_cnt_q    <= '0;
      adv_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      cpl_wr_ptr_q <= cpl_wr_ptr_d;
      cpl_rd_ptr_q <= cpl_rd_ptr_d;
      cpl_cnt_q    <= cpl_cnt_d;
      adv_cnt_q    <= adv_cnt_d;
      adv_q        <= adv_d;
    end
  end

  // Entry storage carries no reset; outputs are masked by the valid flags instead.
  always_ff @(posedge i_clk) begin
    if (push) req_mem_q[wr_ptr_q] <= req_in;
    if (cpl_push) cpl_mem_q[cpl_wr_ptr_q] <= cpl_in;
  end

endmodule

// File: tb/tb_x_23k640_req_queue.sv
// Randomised scoreboard bench for x_23k640_req_queue with a queue-based reference model
// and a behavioural controller that accepts only on advance strobes.
module tb_x_23k640_req_queue;
  localparam int DEPTH     = 4;
  localparam int CPL_DEPTH = 2;
  localparam int ADV_DIV   = 4;
  localparam int TAG_W     = 4;

  typedef struct {
    logic             rd;
    logic [15:0]      addr;
    logic [7:0]       wdata;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic             rd;
    logic [TAG_W-1:0] tag;
    logic [7:0]       rdata;
  } cpl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        accept, rdy;
  logic [7:0]  rdata;
  logic        adv, vld, rdnwr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        adv1, vld1, rdnwr1;
  logic [15:0] addr1;
  logic [7:0]  wdata1;

  x_23k640_req_queue_if #(.TAG_W(TAG_W)) app ();
  x_23k640_req_queue_if #(.TAG_W(TAG_W)) app1 ();

  x_23k640_req_queue #(.DEPTH(DEPTH), .CPL_DEPTH(CPL_DEPTH), .ADV_DIV(ADV_DIV), .TAG_W(TAG_W)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .app(app), .o_advance(adv), .o_valid(vld), .i_accept(accept),
    .o_rd_n_wr(rdnwr), .o_addr(addr), .o_wdata(wdata), .i_ready(rdy), .i_rdata(rdata));

  x_23k640_req_queue #(.DEPTH(DEPTH), .CPL_DEPTH(CPL_DEPTH), .ADV_DIV(1), .TAG_W(TAG_W)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .app(app1), .o_advance(adv1), .o_valid(vld1), .i_accept(1'b0),
    .o_rd_n_wr(rdnwr1), .o_addr(addr1), .o_wdata(wdata1), .i_ready(1'b0), .i_rdata(8'h00));

  assign app1.req_valid   = 1'b0;
  assign app1.req_rd_n_wr = 1'b0;
  assign app1.req_addr    = 16'h0;
  assign app1.req_wdata   = 8'h0;
  assign app1.req_tag     = '0;
  assign app1.cpl_ready   = 1'b0;

  req_t mq[$];
  cpl_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;
  bit   acc_en = 1'b0;
  int   acc_pct = 100;
  logic [7:0] rd_val = 8'h00;
  bit   prev_full = 1'b0;
  int   cyc = 0;
  int   last_adv = -100;
  req_t h_r;
  cpl_t c_w, c_m;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Invariants against the model, then the controller model decides whether to accept the head.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (chk_en) begin
      check("o_valid", 32'(vld), 32'(mq.size() != 0));
      check("o_req_ready", 32'(app.req_ready), 32'(mq.size() != DEPTH));
      if (mq.size() != 0) begin
        check("o_addr", 32'(addr), 32'(mq[0].addr));
        check("o_wdata", 32'(wdata), 32'(mq[0].wdata));
        check("o_rd_n_wr", 32'(rdnwr), 32'(mq[0].rd));
      end
      check("o_cpl_valid", 32'(app.cpl_valid), 32'(sb.size() != 0));
      if (prev_full) check("adv_while_stalled", 32'(adv), 32'(0));
      if (adv) begin
        check("adv_spacing", 32'((cyc - last_adv) >= ADV_DIV), 32'(1));
        last_adv = cyc;
      end
      prev_full = (sb.size() == CPL_DEPTH);
    end
    accept = 1'b0;
    rdy    = 1'b0;
    rdata  = 8'($urandom);
    if (acc_en && vld && adv && mq.size() != 0 && $urandom_range(99) < acc_pct) begin
      h_r = mq.pop_front();
      accept = 1'b1;
      rdy    = h_r.rd;
      if (h_r.rd) rdata = rd_val;
      c_w.rd    = h_r.rd;
      c_w.tag   = h_r.tag;
      c_w.rdata = h_r.rd ? rd_val : 8'h00;
      sb.push_back(c_w);
      rd_val = 8'($urandom);
    end
  end

  // Completion monitor: pops the scoreboard whenever the application consumes a completion.
  always @(negedge clk) begin
    if (chk_en && app.cpl_valid && app.cpl_ready) begin
      if (sb.size() == 0) begin
        check("cpl_unexpected", 32'(1), 32'(0));
      end else begin
        c_m = sb.pop_front();
        check("cpl_tag", 32'(app.cpl_tag), 32'(c_m.tag));
        check("cpl_rd_n_wr", 32'(app.cpl_rd_n_wr), 32'(c_m.rd));
        check("cpl_rdata", 32'(app.cpl_rdata), 32'(c_m.rdata));
      end
    end
  end

  task automatic send(input logic rd, input logic [15:0] a, input logic [7:0] d,
                      input logic [TAG_W-1:0] t, input int max_cyc);
    req_t r;
    bit   taken;
    int   n;
    r.rd = rd; r.addr = a; r.wdata = d; r.tag = t;
    app.req_valid = 1'b1; app.req_rd_n_wr = rd; app.req_addr = a;
    app.req_wdata = d; app.req_tag = t;
    n = 0;
    while (1) begin
      taken = app.req_ready;
      if (taken) mq.push_back(r);
      tick();
      if (taken) break;
      n++;
      if (n > max_cyc) begin
        check("req_accept_timeout", 32'(0), 32'(1));
        break;
      end
    end
    app.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((mq.size() != 0 || sb.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain", 32'(mq.size() + sb.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   taken;
    req_t cur;
    int   n;
    rst_n = 1'b0; accept = 1'b0; rdy = 1'b0; rdata = 8'h00;
    app.req_valid = 1'b0; app.req_rd_n_wr = 1'b0; app.req_addr = '0;
    app.req_wdata = '0; app.req_tag = '0; app.cpl_ready = 1'b1;
    cur = '{1'b0, 16'h0, 8'h0, '0};
    repeat (3) tick();

    check("rst_req_ready", 32'(app.req_ready), 32'(1));
    check("rst_o_valid", 32'(vld), 32'(0));
    check("rst_cpl_valid", 32'(app.cpl_valid), 32'(0));
    check("rst_advance", 32'(adv), 32'(0));
    check("rst_head_fields", {15'(0), rdnwr, addr}, 32'(0));
    check("rst_wdata", 32'(wdata), 32'(0));
    check("rst_cpl_fields", 32'({app.cpl_rd_n_wr, app.cpl_tag, app.cpl_rdata}), 32'(0));
    check("rst_div1_advance", 32'(adv1), 32'(0));

    rst_n = 1'b1;
    chk_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("adv_div4_idle", 32'(adv), 32'((c % ADV_DIV) == (ADV_DIV - 1)));
      check("adv_div1_idle", 32'(adv1), 32'(1));
    end
    check("div1_idle_outputs", {vld1, rdnwr1, addr1, wdata1, app1.req_ready, app1.cpl_valid}, 32'(2));

    // Single write, then single read with known read data.
    acc_en = 1'b1; acc_pct = 100;
    send(1'b0, 16'h1234, 8'hA5, 4'd3, 20);
    wait_drain(60);
    rd_val = 8'h5A;
    send(1'b1, 16'h0010, 8'h00, 4'd7, 20);
    wait_drain(60);

    // Fill the request FIFO with the controller idle; a fifth request must wait.
    acc_en = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(1'($urandom), 16'($urandom), 8'($urandom), TAG_W'(i + 8), 4);
    app.req_valid = 1'b1; app.req_rd_n_wr = 1'b0; app.req_addr = 16'hBEEF;
    app.req_wdata = 8'h3C; app.req_tag = TAG_W'(12);
    for (int i = 0; i < 3; i++) begin
      check("full_not_ready", 32'(app.req_ready), 32'(0));
      tick();
    end
    acc_en = 1'b1;
    send(1'b0, 16'hBEEF, 8'h3C, TAG_W'(12), 40);
    wait_drain(120);

    // Completion back-pressure: two completions fill the buffer and the third request stalls.
    app.cpl_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(1'(i), 16'h0100 + 16'(i), 8'(i), TAG_W'(i + 1), 20);
    repeat (40) tick();
    check("stall_cpl_held", 32'(sb.size()), 32'(CPL_DEPTH));
    check("stall_head_held", 32'(mq.size()), 32'(1));
    check("stall_no_advance", 32'(adv), 32'(0));
    app.cpl_ready = 1'b1;
    wait_drain(120);

    // Randomised traffic.
    acc_pct = 60;
    for (int i = 0; i < 500; i++) begin
      app.cpl_ready = ($urandom_range(3) != 0);
      if (!app.req_valid && $urandom_range(1) == 1) begin
        cur.rd = 1'($urandom); cur.addr = 16'($urandom);
        cur.wdata = 8'($urandom); cur.tag = TAG_W'($urandom);
        app.req_valid = 1'b1; app.req_rd_n_wr = cur.rd; app.req_addr = cur.addr;
        app.req_wdata = cur.wdata; app.req_tag = cur.tag;
      end
      taken = app.req_valid && app.req_ready;
      if (taken) mq.push_back(cur);
      tick();
      if (taken) app.req_valid = 1'b0;
    end
    app.req_valid = 1'b0;
    app.cpl_ready = 1'b1;
    acc_pct = 100;
    wait_drain(200);

    // Reset with queued requests and a pending completion.
    app.cpl_ready = 1'b0;
    send(1'b1, 16'h0042, 8'h00, TAG_W'(5), 20);
    n = 0;
    while (sb.size() != 1 && n < 40) begin
      tick();
      n++;
    end
    acc_en = 1'b0;
    check("pre_reset_cpl_pending", 32'(sb.size()), 32'(1));
    for (int i = 0; i < 3; i++)
      send(1'b0, 16'h0200 + 16'(i), 8'(i), TAG_W'(i), 4);
    check("pre_reset_queued", 32'(mq.size()), 32'(3));
    rst_n = 1'b0;
    chk_en = 1'b0;
    tick();
    check("mid_rst_o_valid", 32'(vld), 32'(0));
    check("mid_rst_cpl_valid", 32'(app.cpl_valid), 32'(0));
    check("mid_rst_req_ready", 32'(app.req_ready), 32'(1));
    check("mid_rst_advance", 32'(adv), 32'(0));
    mq.delete();
    sb.delete();
    prev_full = 1'b0;
    last_adv = -100;
    rst_n = 1'b1;
    app.cpl_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    acc_en = 1'b1;
    send(1'b0, 16'h0ABC, 8'h77, TAG_W'(9), 20);
    wait_drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/x_23k640_req_queue.md
Name: x_23K640_req_queue

Overview:
- Request/completion front-end placed directly upstream of the 23K640 SPI SRAM controller.
- Buffers application read/write requests in a tagged FIFO and presents the head entry to the controller, holding it stable until the controller accepts it.
- Captures read data and write acknowledges into a completion buffer, returned to the application in order.
- Generates the controller's i_advance strobe and stalls it when the completion buffer is full.

Parameters:
- DEPTH, 4: request FIFO entries; power of 2, at least 2.
- CPL_DEPTH, 2: completion buffer entries; power of 2, at least 2.
- ADV_DIV, 4: o_advance pulses once every ADV_DIV clocks; at least 1 (1 means every cycle).
- TAG_W, 4: request/completion tag width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_req_valid  in  1  application request valid
- o_req_ready  out  1  request accepted this cycle when high together with i_req_valid
- i_req_rd_n_wr  in  1  1 = read, 0 = write
- i_req_addr  in  16  SRAM byte address
- i_req_wdata  in  8  write data (ignored for reads)
- i_req_tag  in  TAG_W  request tag, returned with the completion
- o_cpl_valid  out  1  completion valid
- i_cpl_ready  in  1  application consumes the completion
- o_cpl_rd_n_wr  out  1  type of the completed request
- o_cpl_tag  out  TAG_W  tag of the completed request
- o_cpl_rdata  out  8  read data; 0 for writes
- o_advance  out  1  advance strobe to the controller
- o_valid  out  1  head request valid to the controller
- i_accept  in  1  controller pops the head (one-cycle pulse)
- o_rd_n_wr  out  1  head request type
- o_addr  out  16  head address
- o_wdata  out  8  head write data
- i_ready  in  1  controller read-completion pulse
- i_rdata  in  8  controller read data, valid when i_ready is high

Behaviour:
- Reset: i_rst_n low at a clock edge clears everything.
  - FIFO and completion buffer pointers and counts go to 0; the advance counter goes to 0.
  - Output reset values: o_req_ready=1, o_valid=0, o_cpl_valid=0, o_advance=0, o_addr/o_wdata/o_rd_n_wr/o_cpl_*=0.
  - A reset mid-transaction discards all entries; the controller shares the same system reset, so both restart together.
- Request FIFO:
  - Push when i_req_valid & o_req_ready. o_req_ready = (count != DEPTH), registered-count based, with no combinational path from i_accept.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, o_req_ready stays 0 even if a pop happens that cycle.
  - Pointers wrap modulo DEPTH.
- Head presentation:
  - o_valid = (count != 0).
  - o_addr, o_wdata and o_rd_n_wr come directly from the head entry and stay stable until the i_accept pulse.
  - The controller samples them bit-serially throughout the transaction, so the head entry must not change before i_accept.
  - Its first request after reset passes through its configuration sequence before accepting; the head simply stays valid meanwhile.
- Pop on i_accept: the head's tag and type are written into the completion buffer that same cycle.
  - Read: o_cpl_rdata = i_rdata, captured on that cycle; i_ready coincides with i_accept for reads.
  - Write: o_cpl_rdata = 0.
  - i_accept while the FIFO is empty is a protocol error: ignored, no pointer change.
  - i_ready without i_accept is ignored.
- Completion buffer:
  - o_cpl_valid = (cpl_count != 0); pop on o_cpl_valid & i_cpl_ready.
  - Completions return in issue order; a same-cycle push and pop is allowed.
- Advance generator:
  - The counter runs 0..ADV_DIV-1 and wraps.
  - o_advance is registered and pulses high for 1 cycle when the counter reaches ADV_DIV-1 and stall = 0.
  - stall = (cpl_count == CPL_DEPTH). While stalled, the counter holds and o_advance = 0.
  - This guarantees that no i_accept arrives while the completion buffer is full.
  - The counter runs regardless of o_valid, because the controller needs advance to toggle its clock while idle.
- Widths: all counts are log2(depth)+1 bits wide; no arithmetic beyond pointer increment.

Test Plan:
- Reset, then write addr=0x1234 data=0xA5 tag=3 -> o_valid=1, o_addr=0x1234 held until i_accept; then completion tag=3, rd_n_wr=0, rdata=0x00.
- Read addr=0x0010 tag=7, model returns i_rdata=0x5A with i_ready+i_accept -> completion tag=7, rd_n_wr=1, rdata=0x5A.
- Push 4 requests with no accept (DEPTH=4) -> o_req_ready=0 after the 4th; a 5th i_req_valid is not taken; one accept -> o_req_ready=1 the next cycle; tag order preserved.
- Hold i_cpl_ready=0 through 2 completions (CPL_DEPTH=2) -> o_advance stays 0 until i_cpl_ready=1; no completion is lost.
- ADV_DIV=4, idle -> o_advance pulses on cycles 3, 7, 11 after reset release; ADV_DIV=1 -> pulses every cycle.
- Assert i_rst_n=0 with 3 queued requests and 1 pending completion -> next cycle o_valid=0, o_cpl_valid=0, o_req_ready=1.
